// File: rtl/up_sampler_timing_ctrl_pkg.sv
// Shared types and constants for the up-sampler timing controller.
package up_sampler_pkg;

  // Controller states: idle, running, or draining to the next symbol boundary.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_CLKS_PER_SAM = 4;
  localparam int DEF_UP1          = 2;
  localparam int DEF_UP2          = 2;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/up_sampler_timing_ctrl_counter.sv
// Modulo-N counter with synchronous clear; wrap flags the advance out of N-1.
module mod_n_counter
  import up_sampler_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last = (r_count == W'(N - 1));
  assign wrap   = adv && w_last;
  assign count  = r_count;

  // Count register: clear has priority, otherwise advance and wrap at N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {W{1'b0}};
    end else if (clr) begin
      r_count <= {W{1'b0}};
    end else if (wrap) begin
      r_count <= {W{1'b0}};
    end else if (adv) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/up_sampler_timing_ctrl.sv
// Strobe generator for the two-stage up-sampler chain with start/drain/resync.
module up_sampler_timing_ctrl
  import up_sampler_pkg::*;
#(
  parameter  int CLKS_PER_SAM = DEF_CLKS_PER_SAM,
  parameter  int UP1          = DEF_UP1,
  parameter  int UP2          = DEF_UP2,
  parameter  int SYM_CNT_W    = 16,
  localparam int SPS          = UP1 * UP2,
  localparam int IDX_W        = clog2_min1(UP1 * UP2),
  localparam int DIV_W        = clog2_min1(CLKS_PER_SAM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_req,
  output logic                 sam_clk,
  output logic                 int_clk,
  output logic                 sym_clk,
  output logic [IDX_W-1:0]     sam_idx,
  output logic [SYM_CNT_W-1:0] sym_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned UP2_U = UP2;

  state_t                 r_state, w_next_state;
  logic                   r_sam_clk, r_int_clk, r_sym_clk, r_busy, r_done;
  logic [IDX_W-1:0]       r_sam_idx;
  logic [SYM_CNT_W-1:0]   r_sym_cnt;

  // Divider position itself is not needed; only its wrap matters.
  logic [DIV_W-1:0]       w_div_cnt_unused;
  logic                   w_div_wrap;
  logic [IDX_W-1:0]       w_smp_cnt, w_smp_next;
  logic                   w_smp_wrap;
  logic                   w_sam_tick, w_cnt_clr, w_int_hit;
  logic                   w_sam, w_int, w_sym, w_done, w_cnt_inc;
  logic [IDX_W-1:0]       w_idx;

  mod_n_counter #(.N(CLKS_PER_SAM)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (w_cnt_clr),
    .adv   (1'b1),
    .count (w_div_cnt_unused),
    .wrap  (w_div_wrap)
  );

  mod_n_counter #(.N(SPS)) u_smp (
    .clk   (clk),
    .reset (reset),
    .clr   (w_cnt_clr),
    .adv   (w_sam_tick),
    .count (w_smp_cnt),
    .wrap  (w_smp_wrap)
  );

  // A sample tick is a divider wrap while active; its wrap of the sample
  // counter marks the edge where the next symbol boundary is due.
  assign w_sam_tick = (r_state != IDLE) && w_div_wrap;
  assign w_smp_next = w_smp_wrap ? {IDX_W{1'b0}} : (w_smp_cnt + IDX_W'(1));
  assign w_int_hit  = ((32'(w_smp_next) % UP2_U) == 32'd0);

  // Next-state and next-output decode; drain beats resync, boundary ends drain.
  always_comb begin
    w_next_state = r_state;
    w_sam        = 1'b0;
    w_int        = 1'b0;
    w_sym        = 1'b0;
    w_done       = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_idx        = r_sam_idx;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        w_idx     = {IDX_W{1'b0}};
        if (enable) begin
          w_next_state = RUN;
          w_sam        = 1'b1;
          w_int        = 1'b1;
          w_sym        = 1'b1;
          w_cnt_inc    = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          if (w_smp_wrap) begin
            w_next_state = IDLE;
            w_done       = 1'b1;
            w_cnt_clr    = 1'b1;
            w_idx        = {IDX_W{1'b0}};
          end else begin
            w_next_state = DRAIN;
            if (w_sam_tick) begin
              w_sam = 1'b1;
              w_int = w_int_hit;
              w_idx = w_smp_next;
            end else begin
              w_sam = 1'b0;
            end
          end
        end else if (sync_req) begin
          w_cnt_clr = 1'b1;
          w_sam     = 1'b1;
          w_int     = 1'b1;
          w_sym     = 1'b1;
          w_cnt_inc = 1'b1;
          w_idx     = {IDX_W{1'b0}};
        end else if (w_sam_tick) begin
          w_sam     = 1'b1;
          w_int     = w_int_hit;
          w_sym     = w_smp_wrap;
          w_cnt_inc = w_smp_wrap;
          w_idx     = w_smp_next;
        end else begin
          w_sam = 1'b0;
        end
      end
      DRAIN: begin
        if (w_smp_wrap) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_idx        = {IDX_W{1'b0}};
        end else if (w_sam_tick) begin
          w_sam = 1'b1;
          w_int = w_int_hit;
          w_idx = w_smp_next;
        end else begin
          w_sam = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_clr    = 1'b1;
        w_idx        = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_sam_clk <= 1'b0;
      r_int_clk <= 1'b0;
      r_sym_clk <= 1'b0;
      r_sam_idx <= {IDX_W{1'b0}};
      r_sym_cnt <= {SYM_CNT_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_sam_clk <= w_sam;
      r_int_clk <= w_int;
      r_sym_clk <= w_sym;
      r_sam_idx <= w_idx;
      r_sym_cnt <= w_cnt_inc ? (r_sym_cnt + SYM_CNT_W'(1)) : r_sym_cnt;
      r_busy    <= (w_next_state != IDLE);
      r_done    <= w_done;
    end
  end

  assign sam_clk = r_sam_clk;
  assign int_clk = r_int_clk;
  assign sym_clk = r_sym_clk;
  assign sam_idx = r_sam_idx;
  assign sym_cnt = r_sym_cnt;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_up_sampler_timing_ctrl.sv
// Bench: three parameterisations driven in lockstep, each against a
// time-since-boundary reference model.
module tb_up_sampler_timing_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic sync_req;

  logic       o_sam  [3];
  logic       o_int  [3];
  logic       o_sym  [3];
  logic [1:0] o_idx  [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic [15:0] o_cnt0;
  logic [3:0]  o_cnt1;
  logic [2:0]  o_cnt2;

  // Configurations: clocks per sample, samples per symbol, UP2, counter width.
  int cfg_cps [3] = '{4, 1, 3};
  int cfg_sps [3] = '{4, 4, 3};
  int cfg_up2 [3] = '{2, 2, 1};
  int cfg_cw  [3] = '{16, 4, 3};

  // Reference model state: 0 idle, 1 run, 2 drain; t = clocks since boundary.
  int m_st [3];
  int m_t  [3];
  bit e_sam [3], e_int [3], e_sym [3], e_busy [3], e_done [3];
  int e_idx [3];
  int e_cnt [3];

  int n_checks = 0;
  int n_errors = 0;

  up_sampler_timing_ctrl #(.CLKS_PER_SAM(4), .UP1(2), .UP2(2), .SYM_CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .sync_req(sync_req),
    .sam_clk(o_sam[0]), .int_clk(o_int[0]), .sym_clk(o_sym[0]), .sam_idx(o_idx[0]),
    .sym_cnt(o_cnt0), .busy(o_busy[0]), .done(o_done[0]));

  up_sampler_timing_ctrl #(.CLKS_PER_SAM(1), .UP1(2), .UP2(2), .SYM_CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .sync_req(sync_req),
    .sam_clk(o_sam[1]), .int_clk(o_int[1]), .sym_clk(o_sym[1]), .sam_idx(o_idx[1]),
    .sym_cnt(o_cnt1), .busy(o_busy[1]), .done(o_done[1]));

  up_sampler_timing_ctrl #(.CLKS_PER_SAM(3), .UP1(3), .UP2(1), .SYM_CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .sync_req(sync_req),
    .sam_clk(o_sam[2]), .int_clk(o_int[2]), .sym_clk(o_sym[2]), .sam_idx(o_idx[2]),
    .sym_cnt(o_cnt2), .busy(o_busy[2]), .done(o_done[2]));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return {16'd0, o_cnt0};
      1:       return {28'd0, o_cnt1};
      default: return {29'd0, o_cnt2};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_t[i] = 0;
      e_sam[i] = 1'b0; e_int[i] = 1'b0; e_sym[i] = 1'b0;
      e_busy[i] = 1'b0; e_done[i] = 1'b0; e_idx[i] = 0; e_cnt[i] = 0;
    end
  endtask

  task automatic give_boundary(input int i);
    m_t[i] = 0;
    e_sam[i] = 1'b1; e_int[i] = 1'b1; e_sym[i] = 1'b1; e_idx[i] = 0;
    e_cnt[i] = (e_cnt[i] + 1) % (1 << cfg_cw[i]);
  endtask

  task automatic finish_drain(input int i);
    m_st[i] = 0; m_t[i] = 0; e_done[i] = 1'b1; e_idx[i] = 0;
  endtask

  task automatic advance(input int i, input int tn);
    m_t[i] = tn;
    if (tn % cfg_cps[i] == 0) begin
      e_sam[i] = 1'b1;
      e_idx[i] = tn / cfg_cps[i];
      e_int[i] = ((tn / cfg_cps[i]) % cfg_up2[i]) == 0;
    end
  endtask

  // One clock edge of the reference model given the sampled inputs.
  task automatic model_step(input bit en, input bit sr);
    for (int i = 0; i < 3; i++) begin
      int tn;
      bit bdue;
      tn = m_t[i] + 1;
      bdue = (tn == cfg_cps[i] * cfg_sps[i]);
      e_sam[i] = 1'b0; e_int[i] = 1'b0; e_sym[i] = 1'b0; e_done[i] = 1'b0;
      case (m_st[i])
        0: begin
          if (en) begin
            m_st[i] = 1;
            give_boundary(i);
          end else begin
            e_idx[i] = 0;
          end
        end
        1: begin
          if (!en) begin
            if (bdue) finish_drain(i);
            else begin
              m_st[i] = 2;
              advance(i, tn);
            end
          end else if (sr || bdue) begin
            give_boundary(i);
          end else begin
            advance(i, tn);
          end
        end
        default: begin
          if (bdue) finish_drain(i);
          else advance(i, tn);
        end
      endcase
      e_busy[i] = (m_st[i] != 0);
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s.sam%0d", ctx, i), {31'd0, o_sam[i]}, {31'd0, e_sam[i]});
      check_val($sformatf("%s.int%0d", ctx, i), {31'd0, o_int[i]}, {31'd0, e_int[i]});
      check_val($sformatf("%s.sym%0d", ctx, i), {31'd0, o_sym[i]}, {31'd0, e_sym[i]});
      check_val($sformatf("%s.idx%0d", ctx, i), {30'd0, o_idx[i]}, 32'(e_idx[i]));
      check_val($sformatf("%s.cnt%0d", ctx, i), obs_cnt(i), 32'(e_cnt[i]));
      check_val($sformatf("%s.busy%0d", ctx, i), {31'd0, o_busy[i]}, {31'd0, e_busy[i]});
      check_val($sformatf("%s.done%0d", ctx, i), {31'd0, o_done[i]}, {31'd0, e_done[i]});
    end
  endtask

  // Drive inputs at a falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input bit en, input bit sr, input string ctx);
    enable = en;
    sync_req = sr;
    @(posedge clk);
    model_step(en, sr);
    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    bit en_lvl;
    bit d_en;
    bit d_sr;
    reset = 1'b0;
    enable = 1'b0;
    sync_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Directed: start, drain, restart, resync, drain on boundary, conflict.
    for (int k = 0; k < 70; k++) begin
      d_en = !((k >= 6 && k <= 17) || k == 44 || k == 45 || (k >= 56 && k <= 63));
      d_sr = (k == 28) || (k == 56);
      cycle(d_en, d_sr, $sformatf("dir%0d", k));
      if (k == 0) begin
        check_val("first_sym", {31'd0, o_sym[0]}, 32'd1);
        check_val("first_cnt", {16'd0, o_cnt0}, 32'd1);
      end
      if (k == 12) check_val("drain_sam12", {31'd0, o_sam[0]}, 32'd1);
      if (k == 16) begin
        check_val("drain_done16", {31'd0, o_done[0]}, 32'd1);
        check_val("drain_nosam16", {31'd0, o_sam[0]}, 32'd0);
      end
      if (k == 17) check_val("idle_busy17", {31'd0, o_busy[0]}, 32'd0);
      if (k == 18) check_val("restart_sym18", {31'd0, o_sym[0]}, 32'd1);
      if (k == 28) check_val("resync_sym", {31'd0, o_sym[0]}, 32'd1);
      if (k == 32) check_val("resync_sam", {31'd0, o_sam[0]}, 32'd1);
      if (k == 36) check_val("resync_int", {31'd0, o_int[0]}, 32'd1);
      if (k == 44) check_val("bnd_drain_done", {31'd0, o_done[0]}, 32'd1);
      if (k == 56) check_val("conflict_nosym", {31'd0, o_sym[0]}, 32'd0);
      if (k == 62) check_val("conflict_done", {31'd0, o_done[0]}, 32'd1);
    end

    // Randomised run/stop/resync traffic.
    en_lvl = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) en_lvl = !en_lvl;
      cycle(en_lvl, ($urandom_range(0, 24) == 0), "rnd");
    end

    // Asynchronous reset in the middle of a run.
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, "prerst");
    enable = 1'b1;
    sync_req = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, "post_rst");
    check_val("post_rst_sym", {31'd0, o_sym[0]}, 32'd1);
    check_val("post_rst_cnt", {16'd0, o_cnt0}, 32'd1);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, "tail");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/up_sampler_timing_ctrl.md
Name: up_sampler_timing_ctrl

Overview:
Generates the aligned single-cycle enables (`sam_clk`, `int_clk`, `sym_clk`) that sequence the two-stage 2x/2x up-sampler chain from the fast system clock.
Provides start/stop control with graceful drain to a symbol boundary, and a resync request that realigns the symbol phase.
Sits between the transmitter control logic and the up-sampler/interpolator datapath.

Parameters:
CLKS_PER_SAM, 4, `clk` cycles per output sample (>=1)
UP1, 2, first-stage up-sampling factor (>=1)
UP2, 2, second-stage up-sampling factor (>=1); an interpolator strobe occurs every UP2 samples
SYM_CNT_W, 16, width of the symbol counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; level-sensitive
sync_req  in  1  single-cycle request to realign to a symbol boundary
sam_clk  out  1  sample-rate enable, one `clk` cycle wide
int_clk  out  1  interpolator-rate enable, coincident with every UP2-th `sam_clk`
sym_clk  out  1  symbol-rate enable, coincident with every (UP1*UP2)-th `sam_clk`
sam_idx  out  clog2(UP1*UP2) (min 1)  sample index within the symbol; 0 on the `sym_clk` sample
sym_cnt  out  SYM_CNT_W  number of `sym_clk` pulses issued, modulo 2^SYM_CNT_W
busy  out  1  high when the state is not IDLE
done  out  1  one-cycle pulse when a drain completes

Behaviour:
- Clock and reset:
  - One clock. `reset` is asynchronous and active-low.
  - While `reset` is low: every output is 0, state is IDLE, all counters are 0.
- Output timing:
  - All outputs are registered.
  - Latency from `enable` being sampled high in IDLE to the first strobe is 1 `clk` (the strobe is visible in the cycle after that edge).
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Strobes are 0 and counters are held at 0.
  - On an edge with `enable`=1: go to RUN and issue a boundary, i.e. `sam_clk`, `int_clk` and `sym_clk` all = 1, `sam_idx` = 0, `sym_cnt` +1.
- RUN:
  - The sample divider counts 0..CLKS_PER_SAM-1 and wraps. A wrap issues `sam_clk`.
  - The sample counter counts 0..UP1*UP2-1 and advances once per `sam_clk`. `int_clk` is issued when `(sample count mod UP2)` = 0. `sym_clk` is issued when the sample count = 0.
  - `sam_idx` is updated only on `sam_clk` and held between strobes.
- `sync_req` in RUN:
  - At that edge, clear both counters and issue a boundary (all three strobes, `sam_idx` = 0).
  - The next `sam_clk` follows CLKS_PER_SAM cycles later.
  - `sync_req` is ignored in IDLE and DRAIN.
- Stopping:
  - If `enable` is sampled 0 in RUN, go to DRAIN. Strobes continue unchanged until the edge at which the next boundary would be issued.
  - At that edge: no strobes are issued, `done` = 1, and the state becomes IDLE.
  - If `enable` is sampled 0 exactly on a boundary edge, that boundary is suppressed and `done` pulses at the same edge.
- Simultaneous events:
  - `enable` = 0 together with `sync_req` = 1: the drain wins and `sync_req` is dropped.
  - `enable` rising during DRAIN is ignored. The drain completes, IDLE lasts at least 1 cycle, and the block restarts on the next edge with `enable` = 1.
- `sym_cnt`:
  - Wraps from 2^SYM_CNT_W-1 to 0.
  - It is not cleared by `sync_req` or by a drain; only `reset` clears it.
- Degenerate parameter values:
  - CLKS_PER_SAM = 1: `sam_clk` is high on every RUN cycle.
  - UP2 = 1: `int_clk` equals `sam_clk`.
  - UP1*UP2 = 1: all three strobes are identical.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous). No `done` pulse is generated.

Decomposition:
- Shared package `up_sampler_pkg`:
  - state enum `{IDLE, RUN, DRAIN}`
  - default constants for CLKS_PER_SAM, UP1 and UP2
  - localparam function for the `sam_idx` width (clog2 with a minimum of 1)
- Sub-module `mod_n_counter`:
  - Parameter N; inputs `clk`, `reset`, `clr`, `adv`; outputs `count` and `wrap`.
  - Instantiated twice: sample divider (adv=1) and sample-in-symbol counter (adv=`sam_clk` tick).
  - The FSM and output registers stay in the top level.

Test Plan:
- Reset: assert `reset`=0 mid-RUN with strobes active -> all outputs 0 in the same cycle. Release, `enable`=1 -> first boundary 1 cycle after the enabling edge.
- Defaults, `enable` sampled 1 at edge 0, steady run -> `sam_clk` at cycles 0,4,8,12,16. `int_clk` at 0,8,16. `sym_clk` at 0,16. `sam_idx` = 0,1,2,3,0. `sym_cnt` = 1, then 2 at cycle 16.
- Drain: `enable` sampled 0 at cycle 6 -> `sam_clk` at 8 and 12, nothing at 16, `done`=1 at 16, `busy`=0 from 17. Re-assert `enable` at 17 -> boundary at 18.
- Resync: `sync_req` at cycle 10 in RUN -> all three strobes at 10 with `sam_idx`=0. Next `sam_clk` at 14, `int_clk` at 18, next `sym_clk` at 26.
- Conflict: `sync_req`=1 and `enable`=0 at cycle 10 -> no strobes at 10, drain continues (`sam_clk` at 12), `done` at 16. Also `enable`=0 sampled exactly at 16 -> no strobe, `done` at 16.
- Parameters: CLKS_PER_SAM=1, UP1=UP2=2 -> `sam_clk` every cycle, `int_clk` every 2 cycles, `sym_clk` every 4. Preload `sym_cnt`=65535 via run -> wraps to 0 on the next `sym_clk`.
